// File: rtl/mmio_port_bank.sv
// mmio_port_bank: word-wide output latches, synchronised inputs and maskable change-detect interrupt at consecutive MMIO addresses
module mmio_port_bank #(
    parameter int          WIDTH     = 16,
    parameter int          NUM_PORTS = 4,
    parameter logic [15:0] BASE_ADDR = 16'h2000
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [15:0]                memAddr,
    input  logic                       re_L,
    input  logic                       we_L,
    input  logic [WIDTH-1:0]           wrData,
    output logic [WIDTH-1:0]           rdData,
    output logic                       rdDrive_L,
    input  logic [NUM_PORTS*WIDTH-1:0] swIn,
    output logic [NUM_PORTS*WIDTH-1:0] ledOut,
    output logic                       irq
);
    localparam int          IDXW    = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1;
    localparam logic [16:0] PORTS17 = 17'(NUM_PORTS);

    logic [WIDTH-1:0]     outReg [NUM_PORTS];
    logic [WIDTH-1:0]     sync1  [NUM_PORTS];
    logic [WIDTH-1:0]     sync2  [NUM_PORTS];
    logic [WIDTH-1:0]     prev   [NUM_PORTS];
    logic [NUM_PORTS-1:0] chg;
    logic [NUM_PORTS-1:0] mask;
    logic [NUM_PORTS-1:0] chgSet;
    logic [NUM_PORTS-1:0] chgClr;
    logic [NUM_PORTS-1:0] portSel;
    logic [1:0]           warm;
    logic                 armed;
    logic [16:0]          offset;
    logic                 inRange;
    logic                 portHit;
    logic                 statusHit;
    logic                 maskHit;
    logic                 anyHit;
    logic                 writeEn;
    logic [IDXW-1:0]      portIdx;
    logic [WIDTH-1:0]     rdValue;

    // Offset is taken in 17 bits and qualified by memAddr >= BASE_ADDR so a base near the top never wraps
    assign offset    = {1'b0, memAddr} - {1'b0, BASE_ADDR};
    assign inRange   = memAddr >= BASE_ADDR;
    assign portHit   = inRange && (offset < PORTS17);
    assign statusHit = inRange && (offset == PORTS17);
    assign maskHit   = inRange && (offset == PORTS17 + 17'd1);
    assign anyHit    = portHit || statusHit || maskHit;
    assign portIdx   = offset[IDXW-1:0];
    assign portSel   = portHit ? (NUM_PORTS'(1) << portIdx) : '0;
    assign writeEn   = !we_L;
    assign armed     = warm == 2'd3;

    assign rdDrive_L = !(!re_L && anyHit);
    assign rdData    = rdDrive_L ? '0 : rdValue;
    assign irq       = |(chg & mask);
    assign chgClr    = (writeEn && statusHit) ? wrData[NUM_PORTS-1:0] : '0;

    // Select the register presented on the read path
    always_comb begin
        rdValue = '0;
        if (portHit)
            rdValue = sync2[portIdx];
        else if (statusHit)
            rdValue[NUM_PORTS-1:0] = chg;
        else if (maskHit)
            rdValue[NUM_PORTS-1:0] = mask;
    end

    // A port flags a change once warm-up is over and its synchronised value moved
    always_comb begin
        chgSet = '0;
        for (int i = 0; i < NUM_PORTS; i++)
            chgSet[i] = armed && (sync2[i] != prev[i]);
    end

    // Per-port output latch and input synchroniser chain
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (reset) begin
                outReg[i] <= '0;
                sync1[i]  <= '0;
                sync2[i]  <= '0;
                prev[i]   <= '0;
            end else begin
                sync1[i] <= swIn[i*WIDTH +: WIDTH];
                sync2[i] <= sync1[i];
                prev[i]  <= sync2[i];
                if (writeEn && portSel[i])
                    outReg[i] <= wrData;
            end
        end
    end

    // Sticky change flags (a new set beats a same-cycle clear), mask register and warm-up counter
    always_ff @(posedge clock) begin
        if (reset) begin
            chg  <= '0;
            mask <= '0;
            warm <= '0;
        end else begin
            chg <= (chg & ~chgClr) | chgSet;
            if (writeEn && maskHit)
                mask <= wrData[NUM_PORTS-1:0];
            if (!armed)
                warm <= warm + 2'd1;
        end
    end

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_led
        assign ledOut[i*WIDTH +: WIDTH] = outReg[i];
    end
endmodule
